// File: rtl/keypad_scanner_if.sv
// Keypad matrix bus between the row/column scanner and the keypad/decoder side.
interface keypad_scanner_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic       key_detected;
    logic [3:0] key_row;
    logic [3:0] key_col;

    // Scanner side: drives rows and reports the locked key.
    modport master (
        input  col_n,
        output row_n,
        output key_detected,
        output key_row,
        output key_col
    );

    // Keypad/decoder side: returns columns and consumes the key report.
    modport slave (
        output col_n,
        input  row_n,
        input  key_detected,
        input  key_row,
        input  key_col
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: one-row-at-a-time drive, column sync, single-key lock with ghost rejection.
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES = 3000
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);

    localparam int unsigned CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SWEEP = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    col_meta_q, col_sync_q;
    logic [3:0]    col_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    r_q, r_d, r_nx;
    logic [4:0]    hits_q, hits_d, hits_sum;
    logic [1:0]    cand_row_q, cand_row_d, cand_row_nx;
    logic [3:0]    cand_col_q, cand_col_d, cand_col_nx;
    logic [3:0]    row_n_q, row_n_d;
    logic          det_q, det_d;
    logic [3:0]    key_row_q, key_row_d;
    logic [3:0]    key_col_q, key_col_d;
    logic          sample;
    logic          first_hit;
    logic          sweep_lock;
    logic          hold_lost;

    function automatic logic [2:0] pop4(input logic [3:0] v);
        pop4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Two-flop synchroniser on the asynchronous active-low columns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
        end else begin
            col_meta_q <= kp.col_n;
            col_sync_q <= col_meta_q;
        end
    end

    assign col_s       = ~col_sync_q;
    assign sample      = (cnt_q == CNT_LAST);
    assign hits_sum    = hits_q + 5'(pop4(col_s));
    assign first_hit   = (hits_q == 5'd0) && (col_s != 4'b0000);
    assign cand_row_nx = first_hit ? r_q : cand_row_q;
    assign cand_col_nx = first_hit ? col_s : cand_col_q;
    assign r_nx        = r_q + 2'd1;
    assign sweep_lock  = sample && (r_q == 2'd3) && (hits_sum == 5'd1);
    assign hold_lost   = sample && (col_s != key_col_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_SWEEP;
        else     state_q <= state_d;
    end

    // Next-state: lock on a sweep with exactly one hit, drop when the held column pattern changes.
    always_comb begin
        state_d = ST_SWEEP;
        case (state_q)
            ST_SWEEP: state_d = sweep_lock ? ST_HOLD : ST_SWEEP;
            ST_HOLD:  state_d = hold_lost ? ST_SWEEP : ST_HOLD;
            default:  state_d = ST_SWEEP;
        endcase
    end

    // Next values for the dwell counter, sweep accumulators and registered outputs.
    always_comb begin
        cnt_d      = sample ? '0 : cnt_q + CW'(1);
        r_d        = r_q;
        hits_d     = hits_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        row_n_d    = row_n_q;
        det_d      = det_q;
        key_row_d  = key_row_q;
        key_col_d  = key_col_q;
        case (state_q)
            ST_SWEEP: begin
                if (sweep_lock) begin
                    // Park on the locked row; the wrapped counter gives it a full dwell.
                    det_d      = 1'b1;
                    key_row_d  = 4'b0001 << cand_row_nx;
                    key_col_d  = cand_col_nx;
                    row_n_d    = ~(4'b0001 << cand_row_nx);
                    r_d        = 2'd0;
                    hits_d     = 5'd0;
                    cand_row_d = 2'd0;
                    cand_col_d = 4'b0000;
                end else if (sample && (r_q == 2'd3)) begin
                    r_d        = 2'd0;
                    hits_d     = 5'd0;
                    cand_row_d = 2'd0;
                    cand_col_d = 4'b0000;
                    row_n_d    = 4'b1110;
                end else if (sample) begin
                    r_d        = r_nx;
                    hits_d     = hits_sum;
                    cand_row_d = cand_row_nx;
                    cand_col_d = cand_col_nx;
                    row_n_d    = ~(4'b0001 << r_nx);
                end
            end
            ST_HOLD: begin
                if (hold_lost) begin
                    det_d      = 1'b0;
                    key_row_d  = 4'b0000;
                    key_col_d  = 4'b0000;
                    r_d        = 2'd0;
                    hits_d     = 5'd0;
                    cand_row_d = 2'd0;
                    cand_col_d = 4'b0000;
                    row_n_d    = 4'b1110;
                end
            end
            default: begin
                cnt_d      = '0;
                r_d        = 2'd0;
                hits_d     = 5'd0;
                cand_row_d = 2'd0;
                cand_col_d = 4'b0000;
                row_n_d    = 4'b1110;
                det_d      = 1'b0;
                key_row_d  = 4'b0000;
                key_col_d  = 4'b0000;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            r_q        <= 2'd0;
            hits_q     <= 5'd0;
            cand_row_q <= 2'd0;
            cand_col_q <= 4'b0000;
            row_n_q    <= 4'b1110;
            det_q      <= 1'b0;
            key_row_q  <= 4'b0000;
            key_col_q  <= 4'b0000;
        end else begin
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            hits_q     <= hits_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            row_n_q    <= row_n_d;
            det_q      <= det_d;
            key_row_q  <= key_row_d;
            key_col_q  <= key_col_d;
        end
    end

    assign kp.row_n        = row_n_q;
    assign kp.key_detected = det_q;
    assign kp.key_row      = key_row_q;
    assign kp.key_col      = key_col_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a simple 4x4 switch-matrix model.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] keys;        // bit r*4+c: key at row r, column c is pressed
    logic [3:0]  col_model;
    int          total;
    int          bad;
    logic        seen_det;

    keypad_scanner_if kp_if ();

    keypad_scanner #(.SETTLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_model = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !kp_if.row_n[r]) col_model[c] = 1'b0;
            end
        end
    end
    assign kp_if.col_n = col_model;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_det(input string tag, input logic want, input int maxc);
        int n;
        n = 0;
        while (kp_if.key_detected !== want && n < maxc) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(kp_if.key_detected), 32'(want));
    endtask

    // Align to the edge where row 0 starts a new sweep.
    task automatic align_sweep();
        int n;
        n = 0;
        while (kp_if.row_n !== 4'b0111 && n < 40) begin tick(1); n++; end
        while (kp_if.row_n !== 4'b1110 && n < 40) begin tick(1); n++; end
        chk("align", 32'(kp_if.row_n), 32'(4'b1110));
    endtask

    task automatic watch_no_det(input int n);
        seen_det = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (kp_if.key_detected) seen_det = 1'b1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        keys  = 16'h0000;
        rst   = 1'b1;
        #1;
        // Case 1: reset values and row stepping.
        chk("rst_row_n", 32'(kp_if.row_n), 32'(4'b1110));
        chk("rst_det",   32'(kp_if.key_detected), 32'(1'b0));
        chk("rst_krow",  32'(kp_if.key_row), 32'(4'b0000));
        chk("rst_kcol",  32'(kp_if.key_col), 32'(4'b0000));
        tick(2);
        chk("rst_hold_row_n", 32'(kp_if.row_n), 32'(4'b1110));
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        chk("step0", 32'(kp_if.row_n), 32'(4'b1110));
        tick(1);
        chk("step1", 32'(kp_if.row_n), 32'(4'b1101));
        tick(4);
        chk("step2", 32'(kp_if.row_n), 32'(4'b1011));
        tick(4);
        chk("step3", 32'(kp_if.row_n), 32'(4'b0111));
        tick(4);
        chk("step_wrap", 32'(kp_if.row_n), 32'(4'b1110));

        // Case 2: single key row2/col1.
        keys = 16'h0000;
        keys[2*4 + 1] = 1'b1;
        wait_det("c2_det", 1'b1, 35);
        chk("c2_krow",  32'(kp_if.key_row), 32'(4'b0100));
        chk("c2_kcol",  32'(kp_if.key_col), 32'(4'b0010));
        chk("c2_row_n", 32'(kp_if.row_n), 32'(4'b1011));
        tick(20);
        chk("c2_hold_det",   32'(kp_if.key_detected), 32'(1'b1));
        chk("c2_hold_row_n", 32'(kp_if.row_n), 32'(4'b1011));

        // Case 3: release.
        keys = 16'h0000;
        wait_det("c3_rel", 1'b0, 7);
        chk("c3_krow",  32'(kp_if.key_row), 32'(4'b0000));
        chk("c3_kcol",  32'(kp_if.key_col), 32'(4'b0000));
        chk("c3_row_n", 32'(kp_if.row_n), 32'(4'b1110));
        tick(4);
        chk("c3_resume", 32'(kp_if.row_n), 32'(4'b1101));

        // Case 4: two columns in one row.
        align_sweep();
        keys = 16'h0000;
        keys[1*4 + 0] = 1'b1;
        keys[1*4 + 3] = 1'b1;
        watch_no_det(96);
        chk("c4_ghost_row", 32'(seen_det), 32'(1'b0));

        // Case 5a: same column in two rows.
        keys = 16'h0000;
        tick(40);
        align_sweep();
        keys[0*4 + 2] = 1'b1;
        keys[3*4 + 2] = 1'b1;
        watch_no_det(96);
        chk("c5_ghost_col", 32'(seen_det), 32'(1'b0));

        // Case 5b: lock row0/col2, then add row0/col0.
        keys[3*4 + 2] = 1'b0;
        wait_det("c5_det", 1'b1, 35);
        chk("c5_krow", 32'(kp_if.key_row), 32'(4'b0001));
        chk("c5_kcol", 32'(kp_if.key_col), 32'(4'b0100));
        keys[0*4 + 0] = 1'b1;
        wait_det("c5_add_drop", 1'b0, 7);
        watch_no_det(64);
        chk("c5_two_in_row", 32'(seen_det), 32'(1'b0));

        // Case 6: async reset mid-HOLD.
        keys = 16'h0000;
        keys[3*4 + 3] = 1'b1;
        wait_det("c6_det", 1'b1, 35);
        chk("c6_krow", 32'(kp_if.key_row), 32'(4'b1000));
        chk("c6_kcol", 32'(kp_if.key_col), 32'(4'b1000));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("c6_async_det",   32'(kp_if.key_detected), 32'(1'b0));
        chk("c6_async_row_n", 32'(kp_if.row_n), 32'(4'b1110));
        chk("c6_async_krow",  32'(kp_if.key_row), 32'(4'b0000));
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        chk("c6_restart0", 32'(kp_if.row_n), 32'(4'b1110));
        tick(1);
        chk("c6_restart1", 32'(kp_if.row_n), 32'(4'b1101));
        wait_det("c6_relock", 1'b1, 35);
        chk("c6_relock_kcol", 32'(kp_if.key_col), 32'(4'b1000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
